// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared state encoding and default constants for the reset sequencer
package accel_pkg;

    localparam int DEF_NUM_STREAMS     = 4;
    localparam int DEF_MAX_OUTSTANDING = 16;
    localparam int DEF_RST_HOLD        = 16;
    localparam int DEF_TIMEOUT         = 4096;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } rs_state_e;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/outstanding_counter.sv
// rtl/outstanding_counter.sv - saturating outstanding-burst counter with misuse flag
module outstanding_counter
    import accel_pkg::*;
#(
    parameter int C_MAX = DEF_MAX_OUTSTANDING,
    parameter int W     = cnt_width(C_MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         err
);

    localparam logic [W-1:0] MAX_V = W'(C_MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, paired inc+dec cancel, over/underflow is refused and flagged.
    always_comb begin
        count_d = count_q;
        err     = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count_q == MAX_V) begin
                err = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count_q == '0) begin
                err = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - soft-reset sequencer for stream engines (optional drain timeout: RESET_SEQ_TIMEOUT_EN)
module reset_sequencer
    import accel_pkg::*;
#(
    parameter int C_NUM_STREAMS     = DEF_NUM_STREAMS,
    parameter int C_MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int C_RST_HOLD        = DEF_RST_HOLD,
    parameter int C_TIMEOUT         = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     soft_reset_req,
    input  logic [C_NUM_STREAMS-1:0] stream_idle,
    input  logic                     ar_hs,
    input  logic                     r_last_hs,
    input  logic                     aw_hs,
    input  logic                     b_hs,
    output logic                     quiesce,
    output logic                     stream_rst,
    output logic                     busy,
    output logic                     done,
    output logic                     timed_out,
    output logic                     protocol_err
);

    localparam int CNT_W  = cnt_width(C_MAX_OUTSTANDING);
    localparam int HOLD_W = cnt_width(C_RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(C_RST_HOLD - 1);

    rs_state_e          state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               quiesce_q, quiesce_d;
    logic               stream_rst_q, stream_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               protocol_err_q, protocol_err_d;

    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   wr_cnt;
    logic               rd_err;
    logic               wr_err;
    logic               cnt_clr;
    logic               timeout_hit;

    // Counters are forced to zero for every cycle spent in HOLD, engines being reset.
    assign cnt_clr = (state_d == ST_HOLD);

    outstanding_counter #(
        .C_MAX (C_MAX_OUTSTANDING),
        .W     (CNT_W)
    ) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (ar_hs),
        .dec   (r_last_hs),
        .count (rd_cnt),
        .err   (rd_err)
    );

    outstanding_counter #(
        .C_MAX (C_MAX_OUTSTANDING),
        .W     (CNT_W)
    ) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (aw_hs),
        .dec   (b_hs),
        .count (wr_cnt),
        .err   (wr_err)
    );

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam int TO_W = cnt_width(C_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(C_TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timed_out_q, timed_out_d;

    assign timeout_hit = ((state_q == ST_QUIESCE) || (state_q == ST_DRAIN)) && (to_cnt_q == TO_LAST);

    // Timeout counter sits at zero in IDLE so it starts fresh on QUIESCE entry; flag clears on a new request.
    always_comb begin
        to_cnt_d    = to_cnt_q;
        timed_out_d = timed_out_q;
        if (state_q == ST_IDLE) begin
            to_cnt_d = '0;
            if (soft_reset_req) begin
                timed_out_d = 1'b0;
            end
        end else if (timeout_hit) begin
            timed_out_d = 1'b1;
        end else if ((state_q == ST_QUIESCE) || (state_q == ST_DRAIN)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Timeout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign timed_out = timed_out_q;
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

    // Sequencer next state, plus registered outputs decoded from the next state.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = '0;
                if (soft_reset_req) begin
                    state_d = ST_QUIESCE;
                end
            end
            ST_QUIESCE: begin
                if (timeout_hit) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end else if (&stream_idle) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (timeout_hit || ((rd_cnt == '0) && (wr_cnt == '0))) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        quiesce_d      = (state_d != ST_IDLE);
        busy_d         = (state_d != ST_IDLE);
        stream_rst_d   = (state_d == ST_HOLD);
        done_d         = (state_d == ST_RELEASE);
        protocol_err_d = protocol_err_q | rd_err | wr_err;
    end

    // State and output registers; reset aborts any sequence in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            hold_cnt_q     <= '0;
            quiesce_q      <= 1'b0;
            stream_rst_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            quiesce_q      <= quiesce_d;
            stream_rst_q   <= stream_rst_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign quiesce      = quiesce_q;
    assign stream_rst   = stream_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_reset_req;
    logic [3:0] stream_idle;
    logic       ar_hs, r_last_hs, aw_hs, b_hs;
    logic       quiesce, stream_rst, busy, done, timed_out, protocol_err;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    wire [5:0] outs = {quiesce, stream_rst, busy, done, timed_out, protocol_err};

    always #5 clk = ~clk;

    reset_sequencer #(
        .C_NUM_STREAMS     (4),
        .C_MAX_OUTSTANDING (16),
        .C_RST_HOLD        (16),
        .C_TIMEOUT         (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .soft_reset_req (soft_reset_req),
        .stream_idle    (stream_idle),
        .ar_hs          (ar_hs),
        .r_last_hs      (r_last_hs),
        .aw_hs          (aw_hs),
        .b_hs           (b_hs),
        .quiesce        (quiesce),
        .stream_rst     (stream_rst),
        .busy           (busy),
        .done           (done),
        .timed_out      (timed_out),
        .protocol_err   (protocol_err)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        soft_reset_req = 1'b0;
        stream_idle    = 4'hF;
        ar_hs          = 1'b0;
        r_last_hs      = 1'b0;
        aw_hs          = 1'b0;
        b_hs           = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (busy === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        soft_reset_req = 1'b1;
        ar_hs          = 1'b1;
        rst            = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_inputs();
        n_cmp++;
        if (outs !== 6'b000000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 000000", outs);
        end
    endtask

    task automatic test_min_sequence();
        int rst_ok;
        do_reset();
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        n_cmp++;
        if (outs !== 6'b101000) begin
            n_bad++;
            $display("FAIL min_quiesce_n1: got %b want 101000", outs);
        end
        tick();
        n_cmp++;
        if (outs !== 6'b101000) begin
            n_bad++;
            $display("FAIL min_drain_n2: got %b want 101000", outs);
        end
        rst_ok = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (outs === 6'b111000) rst_ok++;
        end
        n_cmp++;
        if (rst_ok !== 16) begin
            n_bad++;
            $display("FAIL min_hold_cycles: got %0d want 16", rst_ok);
        end
        tick();
        n_cmp++;
        if (outs !== 6'b101100) begin
            n_bad++;
            $display("FAIL min_release_n19: got %b want 101100", outs);
        end
        tick();
        n_cmp++;
        if (outs !== 6'b000000) begin
            n_bad++;
            $display("FAIL min_back_idle: got %b want 000000", outs);
        end
    endtask

    task automatic test_drain();
        bit ok;
        do_reset();
        ar_hs = 1'b1;
        tick();
        tick();
        tick();
        ar_hs = 1'b0;
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        tick();
        tick();
        tick();
        r_last_hs = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (stream_rst !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_n6_waiting: got rst=%b busy=%b want rst=0 busy=1", stream_rst, busy);
        end
        tick();
        r_last_hs = 1'b0;
        n_cmp++;
        if (stream_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_n7_not_hold: got %b want 0", stream_rst);
        end
        tick();
        n_cmp++;
        if (stream_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_n8_hold: got %b want 1", stream_rst);
        end
        wait_idle(40, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_completes: got %b want 1", ok);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int quiet;
        do_reset();
        stream_idle    = 4'b0111;
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        n_cmp++;
        if (quiesce !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_quiesce: got %b want 1", quiesce);
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        quiet = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (stream_rst === 1'b0 && timed_out === 1'b0) quiet++;
        end
        n_cmp++;
        if (quiet !== 63) begin
            n_bad++;
            $display("FAIL timeout_wait_cycles: got %0d want 63", quiet);
        end
        tick();
        n_cmp++;
        if ({stream_rst, timed_out} !== 2'b11) begin
            n_bad++;
            $display("FAIL timeout_forced_hold: got %b want 11", {stream_rst, timed_out});
        end
        wait_idle(40, ok);
        n_cmp++;
        if (ok !== 1'b1 || timed_out !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: got ok=%b to=%b want 1 1", ok, timed_out);
        end
        stream_idle    = 4'hF;
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        n_cmp++;
        if (timed_out !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_cleared_by_req: got %b want 0", timed_out);
        end
        wait_idle(40, ok);
`else
        quiet = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (stream_rst === 1'b0 && busy === 1'b1 && timed_out === 1'b0) quiet++;
        end
        n_cmp++;
        if (quiet !== 100) begin
            n_bad++;
            $display("FAIL timeout_disabled_waits: got %0d want 100", quiet);
        end
        stream_idle = 4'hF;
        wait_idle(40, ok);
        n_cmp++;
        if (ok !== 1'b1 || timed_out !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_disabled_finish: got ok=%b to=%b want 1 0", ok, timed_out);
        end
`endif
    endtask

    task automatic test_protocol_err();
        bit ok;
        do_reset();
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;
        n_cmp++;
        if (protocol_err !== 1'b1) begin
            n_bad++;
            $display("FAIL perr_underflow: got %b want 1", protocol_err);
        end
        aw_hs = 1'b1;
        tick();
        tick();
        b_hs = 1'b1;
        tick();
        aw_hs = 1'b0;
        b_hs  = 1'b0;
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        tick();
        b_hs = 1'b1;
        tick();
        n_cmp++;
        if (stream_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL perr_n3_drain: got %b want 0", stream_rst);
        end
        tick();
        b_hs = 1'b0;
        n_cmp++;
        if (stream_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL perr_n4_not_early: got %b want 0", stream_rst);
        end
        tick();
        n_cmp++;
        if (stream_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL perr_n5_drained: got %b want 1", stream_rst);
        end
        wait_idle(40, ok);
        n_cmp++;
        if (ok !== 1'b1 || protocol_err !== 1'b1) begin
            n_bad++;
            $display("FAIL perr_sticky: got ok=%b err=%b want 1 1", ok, protocol_err);
        end
        do_reset();
        n_cmp++;
        if (protocol_err !== 1'b0) begin
            n_bad++;
            $display("FAIL perr_rst_clear: got %b want 0", protocol_err);
        end
    endtask

    task automatic test_rst_mid_hold();
        int cycles;
        do_reset();
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (stream_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_in_hold: got %b want 1", stream_rst);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (outs !== 6'b000000) begin
            n_bad++;
            $display("FAIL midrst_outputs: got %b want 000000", outs);
        end
        soft_reset_req = 1'b1;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            soft_reset_req = 1'b0;
            cycles++;
            if (done === 1'b1) break;
        end
        n_cmp++;
        if (cycles !== 19 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_rerun_latency: got %0d want 19", cycles);
        end
    endtask

    task automatic test_ignore_req();
        int start;
        do_reset();
        start = done_cnt;
        ar_hs = 1'b1;
        tick();
        ar_hs = 1'b0;
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        tick();
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        tick();
        n_cmp++;
        if ({busy, stream_rst} !== 2'b10) begin
            n_bad++;
            $display("FAIL ignore_still_drain: got %b want 10", {busy, stream_rst});
        end
        r_last_hs = 1'b1;
        tick();
        r_last_hs = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        n_cmp++;
        if (done_cnt - start !== 1) begin
            n_bad++;
            $display("FAIL ignore_one_done: got %0d want 1", done_cnt - start);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_back_idle: got %b want 0", busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_min_sequence();
        test_drain();
        test_timeout();
        test_protocol_err();
        test_rst_mid_hold();
        test_ignore_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter C_NUM_STREAMS, default 4, number of S2H+H2S stream engines controlled.
REQ-002 SHALL have parameter C_MAX_OUTSTANDING, default 16, maximum outstanding AXI bursts per direction.
REQ-003 SHALL have parameter C_RST_HOLD, default 16, stream_rst assertion length in cycles (>=1).
REQ-004 SHALL have parameter C_TIMEOUT, default 4096, drain timeout in cycles.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: soft_reset_req  in  1  single-cycle request from the settings register bank.
REQ-007 SHALL have ports: stream_idle  in  C_NUM_STREAMS  per-engine "no burst being issued".
REQ-008 SHALL have ports: ar_hs, r_last_hs, aw_hs, b_hs  in  1 each  AXI handshakes (arvalid&arready, rvalid&rready&rlast, awvalid&awready, bvalid&bready).
REQ-009 SHALL have ports: quiesce  out  1  engines block new bursts; stream_rst  out  1  engine reset; busy  out  1  sequence active; done  out  1  completion pulse; timed_out  out  1  sticky; protocol_err  out  1  sticky.

Function
REQ-010 SHALL implement FSM states IDLE, QUIESCE, DRAIN, HOLD, RELEASE; all outputs registered.
REQ-011 IDLE: soft_reset_req=1 at cycle N SHALL give state QUIESCE, quiesce=1, busy=1 at N+1; clears timed_out.
REQ-012 soft_reset_req outside IDLE SHALL be ignored (no queuing, no restart).
REQ-013 QUIESCE SHALL advance to DRAIN the cycle after stream_idle is all-ones.
REQ-014 DRAIN SHALL advance to HOLD the cycle after rd_cnt==0 and wr_cnt==0.
REQ-015 HOLD SHALL assert stream_rst for exactly C_RST_HOLD cycles, then enter RELEASE.
REQ-016 RELEASE SHALL last one cycle: stream_rst=0, done=1, quiesce=1; next state IDLE with quiesce=busy=0.
REQ-017 rd_cnt SHALL increment on ar_hs, decrement on r_last_hs; wr_cnt on aw_hs/b_hs; simultaneous inc+dec SHALL leave count unchanged.
REQ-018 Counter width SHALL be clog2(C_MAX_OUTSTANDING+1); increment at max or decrement at zero SHALL be suppressed and set protocol_err.
REQ-019 Counters SHALL track in all states and SHALL be held at zero during HOLD.
REQ-020 Minimum sequence with all idle and zero outstanding: req N, done at N+3+C_RST_HOLD.

Reset
REQ-021 rst SHALL force IDLE, counters 0, and quiesce, stream_rst, busy, done, timed_out, protocol_err all 0, including mid-sequence.
REQ-022 protocol_err SHALL clear only on rst.

Configuration
REQ-023 With RESET_SEQ_TIMEOUT_EN defined, a cycle counter cleared on QUIESCE entry SHALL, on reaching C_TIMEOUT cycles in QUIESCE+DRAIN, force HOLD and set timed_out.
REQ-024 Without RESET_SEQ_TIMEOUT_EN, QUIESCE/DRAIN SHALL wait indefinitely and timed_out SHALL be constant 0.

Structure
REQ-025 FSM state encoding and default parameter constants SHALL live in shared package accel_pkg.
REQ-026 One sub-module outstanding_counter (inc, dec, count, err), instantiated twice (read, write).

Verification
REQ-027 All idle, counts 0, req at cycle 10 -> quiesce at 11, stream_rst cycles 13-28, done at 29 (C_RST_HOLD=16).
REQ-028 3 ar_hs then req; r_last_hs at cycles +5,+6,+7 -> HOLD entered the cycle after the third r_last_hs.
REQ-029 stream_idle=4'b0111 held, timeout en, C_TIMEOUT=64 -> HOLD 64 cycles after QUIESCE entry, timed_out=1; without macro stays QUIESCE.
REQ-030 b_hs with wr_cnt=0 -> wr_cnt stays 0, protocol_err=1 until rst; aw_hs+b_hs same cycle at count 2 -> stays 2.
REQ-031 rst during HOLD cycle 5 -> next cycle stream_rst=0, busy=0, IDLE; new req then runs full sequence.
REQ-032 second soft_reset_req during DRAIN -> ignored, exactly one done pulse.
